// File: rtl/romix_sequencer_if.sv
// Bundle of host-side and salsa-side signals for romix_sequencer.
//   start/data_in        : host request and initial 1024-bit X ({X1, X0})
//   busy/done/data_out   : run status and final X, valid while done
//   salsa_B/salsa_Bx     : X0/X1 launched into the salsa BlockMix pipeline
//   salsa_Bo/salsa_X0out : new X1/X0 returned by salsa
//   salsa_Xaddr          : early scratchpad index, one cycle ahead of Bo
// slave  = the sequencer side; master = the host + salsa side.
interface romix_sequencer_if;
    logic          start;
    logic [1023:0] data_in;
    logic          busy;
    logic          done;
    logic [1023:0] data_out;
    logic [511:0]  salsa_B;
    logic [511:0]  salsa_Bx;
    logic [511:0]  salsa_Bo;
    logic [511:0]  salsa_X0out;
    logic [9:0]    salsa_Xaddr;

    modport slave (
        input  start, data_in, salsa_Bo, salsa_X0out, salsa_Xaddr,
        output busy, done, data_out, salsa_B, salsa_Bx
    );

    modport master (
        output start, data_in, salsa_Bo, salsa_X0out, salsa_Xaddr,
        input  busy, done, data_out, salsa_B, salsa_Bx
    );
endinterface

// File: rtl/romix_sequencer.sv
// scrypt ROMix sequencer around a pipelined salsa BlockMix stage.
// Runs N write iterations (V[i] = X; X = BlockMix(X)) then N read iterations
// (X ^= V[j]; X = BlockMix(X)), owning the N x 1024 scratchpad.
// Ports:
//   clk   : single clock, posedge
//   reset : synchronous, active-high
//   bus   : romix_sequencer_if.slave (host handshake + salsa launch/return)
module romix_sequencer #(
    parameter int unsigned ADDR_BITS = 10,
    parameter int unsigned SALSA_LAT = 16
) (
    input logic             clk,
    input logic             reset,
    romix_sequencer_if.slave bus
);
    localparam int unsigned N  = 1 << ADDR_BITS;
    localparam int unsigned TW = $clog2(SALSA_LAT + 1);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_t;

    state_t                 state;
    logic [1023:0]          x;
    logic [ADDR_BITS-1:0]   cnt;
    logic [TW-1:0]          t;
    logic [1023:0]          rd;
    logic [1023:0]          data_out;
    logic                   busy;
    logic                   done;
    logic [1023:0]          mem [N];

    logic [1023:0]          result;
    logic                   last_cnt;
    logic                   unused_xaddr;

    assign result       = {bus.salsa_Bo, bus.salsa_X0out};
    assign last_cnt     = (cnt == '1);
    assign unused_xaddr = ^bus.salsa_Xaddr;

    assign bus.salsa_B  = x[511:0];
    assign bus.salsa_Bx = x[1023:512];
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.data_out = data_out;

    // Scratchpad is never cleared; written only at t=0 of a WRITE iteration.
    always_ff @(posedge clk) begin
        if (!reset && state == StWrite && t == '0) begin
            mem[cnt] <= x;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            x        <= '0;
            cnt      <= '0;
            t        <= '0;
            rd       <= '0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        x     <= bus.data_in;
                        cnt   <= '0;
                        t     <= '0;
                        state <= StWrite;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                StWrite, StRead: begin
                    // Xaddr leads Bo by one cycle, so rd is ready at capture.
                    if (t == TW'(SALSA_LAT - 1)) begin
                        rd <= mem[bus.salsa_Xaddr[ADDR_BITS-1:0]];
                    end
                    if (t == TW'(SALSA_LAT)) begin
                        t   <= '0;
                        cnt <= cnt + ADDR_BITS'(1);
                        if (state == StRead && last_cnt) begin
                            x        <= result;
                            data_out <= result;
                            state    <= StDone;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else if (state == StRead || last_cnt) begin
                            // Next iteration is a read: fold in V[j] now.
                            x <= result ^ rd;
                            if (state == StWrite) begin
                                state <= StRead;
                            end
                        end else begin
                            x <= result;
                        end
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_romix_sequencer.sv
// Bench for romix_sequencer with ADDR_BITS=2 (N=4). A behavioural stand-in
// for salsa (fixed mixing function, SALSA_LAT-deep pipeline, early Xaddr)
// drives the salsa return path; a reference ROMix built on the same mixing
// function produces expected results into a scoreboard queue.
module tb_romix_sequencer;
    localparam int unsigned ADDR_BITS = 2;
    localparam int unsigned SALSA_LAT = 16;
    localparam int unsigned N         = 1 << ADDR_BITS;
    localparam int          RUN_CYC   = 2 * N * (SALSA_LAT + 1);
    localparam int          LIMIT     = RUN_CYC + 40;

    logic clk = 1'b0;
    logic reset;

    romix_sequencer_if bus ();

    romix_sequencer #(
        .ADDR_BITS (ADDR_BITS),
        .SALSA_LAT (SALSA_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1023:0] exp_q [$];
    logic [1023:0] exp_v [N];

    function automatic logic [1023:0] mix(input logic [1023:0] x);
        logic [511:0] n0;
        logic [511:0] n1;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  c;
        for (int i = 0; i < 16; i++) begin
            a = x[32*i +: 32];
            b = x[512 + 32*i +: 32];
            n0[32*i +: 32] = a + {b[24:0], b[31:25]} + 32'h9e3779b9 + 32'(i);
        end
        for (int i = 0; i < 16; i++) begin
            b = x[512 + 32*i +: 32];
            c = n0[32*((i + 1) % 16) +: 32];
            n1[32*i +: 32] = b ^ {c[18:0], c[31:19]} ^ 32'h7f4a7c15;
        end
        return {n1, n0};
    endfunction

    // Stand-in salsa: result of a launch appears SALSA_LAT cycles later,
    // with the index bits one cycle earlier.
    logic [1023:0] pipe [SALSA_LAT];
    always @(posedge clk) begin
        pipe[0] <= mix({bus.salsa_Bx, bus.salsa_B});
        for (int k = 1; k < SALSA_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.salsa_X0out = pipe[SALSA_LAT-1][511:0];
    assign bus.salsa_Bo    = pipe[SALSA_LAT-1][1023:512];
    assign bus.salsa_Xaddr = pipe[SALSA_LAT-2][521:512];

    task automatic check_val(input string tag, input logic [1023:0] got,
                             input logic [1023:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_romix(input logic [1023:0] din, output logic [1023:0] xo);
        logic [1023:0] x;
        int unsigned   j;
        x = din;
        for (int i = 0; i < N; i++) begin
            exp_v[i] = x;
            x = mix(x);
        end
        for (int i = 0; i < N; i++) begin
            j = 32'(x[512 +: ADDR_BITS]);
            x = mix(x ^ exp_v[j]);
        end
        xo = x;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a hash, optionally poke start with other data while busy, then
    // check latency, busy width and the result popped from the scoreboard.
    task automatic run_hash(input string tag, input logic [1023:0] din, input bit poke);
        logic [1023:0] e;
        int lat;
        int busy_cnt;
        model_romix(din, e);
        exp_q.push_back(e);
        bus.data_in = din;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        check_val({tag, "_done_fall"}, bus.done, 1'b0);
        lat = 1;
        busy_cnt = 0;
        while (!bus.done && lat < LIMIT) begin
            if (bus.busy) busy_cnt++;
            if (poke && (lat == 5 || lat == 60)) begin
                bus.data_in = ~din;
                bus.start   = 1'b1;
            end else begin
                bus.data_in = din;
                bus.start   = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check_val({tag, "_latency"}, lat, RUN_CYC + 1);
        check_val({tag, "_busy_cycles"}, busy_cnt, RUN_CYC);
        check_val({tag, "_data_out"}, bus.data_out, exp_q.pop_front());
    endtask

    initial begin
        logic [1023:0] din;

        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = '1;
        tick();
        tick();
        check_val("rst_busy", bus.busy, 1'b0);
        check_val("rst_done", bus.done, 1'b0);
        check_val("rst_data_out", bus.data_out, '0);
        check_val("rst_salsa_B", bus.salsa_B, '0);
        check_val("rst_salsa_Bx", bus.salsa_Bx, '0);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (8) tick();

        run_hash("zero", '0, 1'b0);
        repeat (3) tick();
        check_val("done_hold", bus.done, 1'b1);

        for (int k = 0; k < 128; k++) din[8*k +: 8] = 8'(k);
        run_hash("incr", din, 1'b0);
        for (int i = 0; i < N; i++) begin
            check_val($sformatf("mem%0d", i), dut.mem[i], exp_v[i]);
        end

        // Restarts straight out of DONE.
        run_hash("ones", '1, 1'b0);

        for (int k = 0; k < 32; k++) din[32*k +: 32] = $urandom;
        run_hash("busy_prot", din, 1'b1);

        // Reset mid-run, then a clean run must be unaffected.
        for (int k = 0; k < 32; k++) din[32*k +: 32] = $urandom;
        bus.data_in = din;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (49) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("midrst_busy", bus.busy, 1'b0);
        check_val("midrst_done", bus.done, 1'b0);
        check_val("midrst_data_out", bus.data_out, '0);
        check_val("midrst_salsa_B", bus.salsa_B, '0);
        check_val("midrst_salsa_Bx", bus.salsa_Bx, '0);
        repeat (2) tick();
        run_hash("after_rst", '0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
